segment_transition: RTL and testbench
=====================================

# segment_transition

Parametrised segment-transition controller for the modulation and STM pipelines. It generalises segment swapping from two segments to `NumSegment`, and adds finite repetition counting plus an autonomous round-robin mode (`TRANSITION_MODE_EXT`). It sits between the controller register file and the modulation/STM index generators, and drives the active read segment they consume.

## Interface
Parameters:
- `NumSegment`, default 2: number of segments, 2..16.
- `SegWidth`, default `$clog2(NumSegment)`, minimum 1: width of the segment index.
- `RepWidth`, default 16: width of the repeat count. An all-ones value means infinite.
- `TimeWidth`, default 64: width of system time and of the transition value.

Ports:
- `CLK` in 1: the single clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `UPDATE` in 1: one-cycle pulse that latches a transition request.
- `REQ_SEGMENT` in `SegWidth`: requested segment.
- `REQ_MODE` in 8: `transition_mode_t` value.
- `TRANSITION_VALUE` in `TimeWidth`: trigger value. For SYS_TIME it is an absolute time. For GPIO, bits [1:0] select the pin.
- `REP` in `NumSegment`×`RepWidth`: repeat count per segment; the segment plays REP+1 loops.
- `SYS_TIME` in `TimeWidth`: system time, already in the `CLK` domain.
- `GPIO_IN` in 4: synchronised GPIO inputs.
- `LOOP_END` in 1: pulse from the index generator when the active segment's index wraps.
- `SEGMENT` out `SegWidth`: active segment.
- `SWAP` out 1: one-cycle pulse on every change of `SEGMENT` or restart of a segment.
- `PENDING` out 1: a request is armed and waiting for its trigger.
- `STOP` out 1: finite repetition exhausted; the index generator holds its last sample.

## Operation
- State machine states:
  - `RUN`: no request pending.
  - `WAIT`: request armed.
  - `AUTO`: EXT round-robin.
- `UPDATE` handling:
  - `UPDATE` with `REQ_SEGMENT` < `NumSegment` and a known mode latches segment, mode and value, then enters `WAIT`. EXT is the exception and goes to `AUTO`.
  - `UPDATE` with an invalid segment or an unknown mode is ignored; state and outputs are unchanged.
  - `UPDATE` in `WAIT` or `AUTO` replaces the pending request (latest wins).
- Triggers, evaluated in `WAIT`:
  - SYNC_IDX: `LOOP_END`.
  - SYS_TIME: unsigned `SYS_TIME` >= value. A value already in the past fires on the first cycle in `WAIT`.
  - GPIO: rising edge of `GPIO_IN[value[1:0]]`, using a registered previous value. A pin already high at arm time does not fire.
- On trigger:
  - `SEGMENT` takes the latched segment and the loop counter clears to 0.
  - `STOP` clears and `SWAP` pulses; the state goes to `RUN`.
  - A request to the already-active segment still restarts it.
- Loop counting:
  - In `RUN` and `AUTO`, each `LOOP_END` increments the loop counter (`RepWidth` bits), unless `REP[SEGMENT]` is all-ones.
  - In `RUN`, when the counter equals `REP[SEGMENT]` and `LOOP_END` arrives, `STOP` sets and is held. Further `LOOP_END` pulses are ignored until the next swap.
  - In `WAIT`, the active segment keeps counting. `STOP` may set before the trigger and is cleared by the swap.
- `AUTO` mode:
  - Entry swaps to `REQ_SEGMENT` immediately.
  - On REP exhaustion, instead of setting `STOP`, `SEGMENT` advances to (`SEGMENT`+1) mod `NumSegment`, the counter clears and `SWAP` pulses.
  - A segment whose REP is all-ones stays active indefinitely. `STOP` never asserts in `AUTO`.
- Simultaneous events:
  - If `UPDATE` coincides with a trigger or loop completion, `UPDATE` wins. The trigger is not consumed, and the new request is evaluated from the next cycle.
  - A `LOOP_END` that fires a SYNC_IDX swap is not counted for the new segment.

## Timing
- Reset values:
  - `SEGMENT`=0, `SWAP`=0, `PENDING`=0, `STOP`=0.
  - State `RUN`; segment 0 treated as infinite until the first swap; loop counter 0; GPIO history 0.
- Request latency: `UPDATE` sampled at edge t gives `PENDING`=1 from t+1. Triggers are evaluated from t+1.
- Trigger latency: trigger true at edge n gives `SEGMENT`, `SWAP`=1 and `PENDING`=0 from n+1. `SWAP` is high for exactly one cycle.
- EXT latency: `UPDATE` at t gives the swap visible at t+1.
- `STOP` is set at the cycle after the final `LOOP_END` is sampled.
- Reset mid-`WAIT` drops the request; no `SWAP` is produced.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package:
  - `transition_mode_t`, with existing encodings 00/01/02/F0.
  - `NumSegment`.
  - New constants `SegWidth` and `RepInfinite` (all-ones of `RepWidth`).
- One sub-module, `transition_trigger`: mode decode, SYS_TIME compare and GPIO edge detect. It outputs a single `fire` bit.

## Test plan
- SYNC_IDX: `NumSegment`=4, REQ 2, pulse `LOOP_END` 10 cycles later -> `SEGMENT`=2 and `SWAP` one cycle after the pulse; `PENDING` high between.
- SYS_TIME: value 1000, `SYS_TIME` ramps from 990 -> swap visible at the cycle after `SYS_TIME`=1000. Value 5 while `SYS_TIME`=900 -> swap 2 cycles after `UPDATE`.
- GPIO: pin 3 held high at arm -> no swap; low then high -> swap one cycle after the rising edge.
- Finite rep: REP[1]=2 -> `STOP`=1 after the 3rd `LOOP_END`; a 4th `LOOP_END` changes nothing; a new `UPDATE` plus trigger clears `STOP`.
- EXT: REP={1,0,FFFF,0}, start 0 -> sequence 0 (2 loops), 1 (1 loop), 2 held forever, each change with a single `SWAP`.
- Edge cases: invalid segment 5 with `NumSegment`=4 -> ignored. `UPDATE` coinciding with `LOOP_END` in `WAIT` -> new request retained, no swap. `RST_N` low in `WAIT` -> `SEGMENT`=0, `PENDING`=0.

Source files
------------

// File: rtl/segment_transition_pkg.sv
// Shared types and default constants for the segment-transition controller
// that drives the active read segment of the modulation/STM index generators.
package segment_transition_pkg;

  localparam int NumSegment = 2;
  localparam int SegWidth   = (NumSegment > 2) ? $clog2(NumSegment) : 1;
  localparam int RepWidth   = 16;
  localparam int TimeWidth  = 64;
  localparam logic [RepWidth-1:0] RepInfinite = '1;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX = 8'h00,
    TRANSITION_MODE_SYS_TIME = 8'h01,
    TRANSITION_MODE_GPIO     = 8'h02,
    TRANSITION_MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_AUTO
  } state_t;

  function automatic logic mode_is_known(logic [7:0] mode);
    return (mode == TRANSITION_MODE_SYNC_IDX) || (mode == TRANSITION_MODE_SYS_TIME) ||
           (mode == TRANSITION_MODE_GPIO)     || (mode == TRANSITION_MODE_EXT);
  endfunction

endpackage

// File: rtl/segment_transition_if.sv
// Request, trigger-source and active-segment signals shared between the
// controller register file side and the segment-transition controller.
interface segment_transition_if
  import segment_transition_pkg::*;
#(
  parameter int NumSegment = segment_transition_pkg::NumSegment,
  parameter int SegWidth   = segment_transition_pkg::SegWidth,
  parameter int RepWidth   = segment_transition_pkg::RepWidth,
  parameter int TimeWidth  = segment_transition_pkg::TimeWidth
);
  logic                                 UPDATE;
  logic [SegWidth-1:0]                  REQ_SEGMENT;
  logic [7:0]                           REQ_MODE;
  logic [TimeWidth-1:0]                 TRANSITION_VALUE;
  logic [NumSegment-1:0][RepWidth-1:0]  REP;
  logic [TimeWidth-1:0]                 SYS_TIME;
  logic [3:0]                           GPIO_IN;
  logic                                 LOOP_END;
  logic [SegWidth-1:0]                  SEGMENT;
  logic                                 SWAP;
  logic                                 PENDING;
  logic                                 STOP;

  modport master (
    output UPDATE, REQ_SEGMENT, REQ_MODE, TRANSITION_VALUE, REP, SYS_TIME, GPIO_IN, LOOP_END,
    input  SEGMENT, SWAP, PENDING, STOP
  );

  modport slave (
    input  UPDATE, REQ_SEGMENT, REQ_MODE, TRANSITION_VALUE, REP, SYS_TIME, GPIO_IN, LOOP_END,
    output SEGMENT, SWAP, PENDING, STOP
  );
endinterface

// File: rtl/segment_transition_trigger.sv
// Trigger evaluation for an armed request: loop-end sync, absolute system time
// or a rising edge on one of the four GPIO pins.
module transition_trigger
  import segment_transition_pkg::*;
#(
  parameter int TimeWidth = segment_transition_pkg::TimeWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  transition_mode_t     mode_i,
  input  logic [TimeWidth-1:0] value_i,
  input  logic [TimeWidth-1:0] sys_time_i,
  input  logic [3:0]           gpio_i,
  input  logic                 loop_end_i,
  output logic                 fire_o
);

  logic [3:0] gpio_q;
  logic [1:0] pin;

  assign pin = value_i[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_i;
    end
  end

  // NOTE: the output is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fire_o = 1'b0;
    case (mode_i)
      TRANSITION_MODE_SYNC_IDX: fire_o = loop_end_i;
      TRANSITION_MODE_SYS_TIME: fire_o = (sys_time_i >= value_i);
      TRANSITION_MODE_GPIO:     fire_o = gpio_i[pin] & ~gpio_q[pin];
      default:                  fire_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_transition.sv
// N-segment transition controller: arms requests, swaps on trigger, counts
// finite repetitions and runs the autonomous round-robin (EXT) mode.
module segment_transition
  import segment_transition_pkg::*;
#(
  parameter int NumSegment = segment_transition_pkg::NumSegment,
  parameter int SegWidth   = (NumSegment > 2) ? $clog2(NumSegment) : 1,
  parameter int RepWidth   = segment_transition_pkg::RepWidth,
  parameter int TimeWidth  = segment_transition_pkg::TimeWidth
) (
  input logic                 CLK,
  input logic                 RST_N,
  segment_transition_if.slave bus
);

  localparam logic [RepWidth-1:0] RepInf = '1;

  state_t               state_q, state_d;
  logic [SegWidth-1:0]  seg_q, seg_d, req_seg_q, req_seg_d, seg_next;
  transition_mode_t     req_mode_q, req_mode_d;
  logic [TimeWidth-1:0] req_value_q, req_value_d;
  logic [RepWidth-1:0]  cnt_q, cnt_d, rep_cur;
  logic swap_q, swap_d, pending_q, pending_d, stop_q, stop_d, inf_q, inf_d;
  logic fire, req_valid, seg_inf, last_loop, count_en;

  transition_trigger #(.TimeWidth(TimeWidth)) u_trigger (
    .clk        (CLK),
    .rst_n      (RST_N),
    .mode_i     (req_mode_q),
    .value_i    (req_value_q),
    .sys_time_i (bus.SYS_TIME),
    .gpio_i     (bus.GPIO_IN),
    .loop_end_i (bus.LOOP_END),
    .fire_o     (fire)
  );

  always_comb begin
    rep_cur = '0;
    for (int i = 0; i < NumSegment; i++) begin
      if (seg_q == SegWidth'(i)) rep_cur = bus.REP[i];
    end
  end

  // Segment 0 counts as infinite until the first real swap after reset.
  assign seg_inf   = inf_q || (rep_cur == RepInf);
  assign last_loop = (cnt_q == rep_cur);
  assign seg_next  = (seg_q == SegWidth'(NumSegment - 1)) ? '0 : seg_q + 1'b1;
  assign req_valid = bus.UPDATE && (32'(bus.REQ_SEGMENT) < NumSegment) &&
                     mode_is_known(bus.REQ_MODE);

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    req_seg_d   = req_seg_q;
    req_mode_d  = req_mode_q;
    req_value_d = req_value_q;
    cnt_d       = cnt_q;
    stop_d      = stop_q;
    inf_d       = inf_q;
    swap_d      = 1'b0;
    count_en    = 1'b0;

    if (req_valid) begin
      req_seg_d   = bus.REQ_SEGMENT;
      req_mode_d  = transition_mode_t'(bus.REQ_MODE);
      req_value_d = bus.TRANSITION_VALUE;
      if (req_mode_d == TRANSITION_MODE_EXT) begin
        state_d = ST_AUTO;
        seg_d   = bus.REQ_SEGMENT;
        cnt_d   = '0;
        stop_d  = 1'b0;
        inf_d   = 1'b0;
        swap_d  = 1'b1;
      end else begin
        state_d = ST_WAIT;
      end
    end else begin
      unique case (state_q)
        ST_RUN:  count_en = 1'b1;
        ST_WAIT: begin
          if (fire) begin
            state_d = ST_RUN;
            seg_d   = req_seg_q;
            cnt_d   = '0;
            stop_d  = 1'b0;
            inf_d   = 1'b0;
            swap_d  = 1'b1;
          end else begin
            count_en = 1'b1;
          end
        end
        ST_AUTO: begin
          if (bus.LOOP_END && !seg_inf) begin
            if (last_loop) begin
              seg_d  = seg_next;
              cnt_d  = '0;
              swap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (count_en && bus.LOOP_END && !seg_inf && !stop_q) begin
        if (last_loop) stop_d = 1'b1;
        else           cnt_d  = cnt_q + 1'b1;
      end
    end

    pending_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      seg_q       <= '0;
      req_seg_q   <= '0;
      req_mode_q  <= TRANSITION_MODE_SYNC_IDX;
      req_value_q <= '0;
      cnt_q       <= '0;
      swap_q      <= 1'b0;
      pending_q   <= 1'b0;
      stop_q      <= 1'b0;
      inf_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      req_seg_q   <= req_seg_d;
      req_mode_q  <= req_mode_d;
      req_value_q <= req_value_d;
      cnt_q       <= cnt_d;
      swap_q      <= swap_d;
      pending_q   <= pending_d;
      stop_q      <= stop_d;
      inf_q       <= inf_d;
    end
  end

  assign bus.SEGMENT = seg_q;
  assign bus.SWAP    = swap_q;
  assign bus.PENDING = pending_q;
  assign bus.STOP    = stop_q;

endmodule

// File: tb/tb_segment_transition.sv
// Self-checking bench for segment_transition: directed scenarios plus random
// traffic, all compared against a behavioural model of the transition rules.
module tb_segment_transition;
  import segment_transition_pkg::*;

  localparam int NSEG = 4;
  localparam int SW   = 3;
  localparam int RW   = 16;
  localparam int TW   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  segment_transition_if #(.NumSegment(NSEG), .SegWidth(SW), .RepWidth(RW), .TimeWidth(TW)) bus ();

  segment_transition #(.NumSegment(NSEG), .SegWidth(SW), .RepWidth(RW), .TimeWidth(TW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: which segment plays, how many loops it has completed,
  // whether a request is waiting, and whether round-robin play is active.
  int          m_seg, m_loops;
  bit          m_swap, m_pending, m_stop, m_auto, m_seg0_inf;
  int          m_req;
  logic [7:0]  m_mode;
  logic [63:0] m_value;
  logic [3:0]  m_gprev;

  task automatic model_reset();
    m_seg = 0; m_loops = 0; m_swap = 0; m_pending = 0; m_stop = 0;
    m_auto = 0; m_seg0_inf = 1; m_req = 0; m_mode = 8'h00; m_value = '0; m_gprev = '0;
  endtask

  task automatic model_step();
    bit fire, upd_ok, plays_forever;
    int rep;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_swap = 0;
    rep = int'(bus.REP[m_seg]);
    plays_forever = m_seg0_inf || (rep == 32'hFFFF);
    upd_ok = bus.UPDATE && (int'(bus.REQ_SEGMENT) < NSEG) &&
             (bus.REQ_MODE inside {8'h00, 8'h01, 8'h02, 8'hF0});
    fire = 0;
    if (m_pending) begin
      if (m_mode == 8'h00) fire = bus.LOOP_END;
      else if (m_mode == 8'h01) fire = (bus.SYS_TIME >= m_value);
      else if (m_mode == 8'h02) fire = bus.GPIO_IN[m_value[1:0]] && !m_gprev[m_value[1:0]];
    end
    if (upd_ok) begin
      m_req = int'(bus.REQ_SEGMENT); m_mode = bus.REQ_MODE; m_value = bus.TRANSITION_VALUE;
      if (bus.REQ_MODE == 8'hF0) begin
        m_auto = 1; m_pending = 0; m_seg = m_req; m_loops = 0; m_stop = 0; m_seg0_inf = 0; m_swap = 1;
      end else begin
        m_auto = 0; m_pending = 1;
      end
    end else if (fire) begin
      m_seg = m_req; m_loops = 0; m_stop = 0; m_seg0_inf = 0; m_swap = 1; m_pending = 0;
    end else if (bus.LOOP_END && !plays_forever) begin
      // The segment has finished all of its REP+1 loops when this loop completes.
      if (m_auto) begin
        if (m_loops + 1 == rep + 1) begin
          m_seg = (m_seg + 1) % NSEG; m_loops = 0; m_swap = 1;
        end else m_loops++;
      end else if (!m_stop) begin
        if (m_loops + 1 == rep + 1) m_stop = 1;
        else m_loops++;
      end
    end
    m_gprev = bus.GPIO_IN;
  endtask

  function automatic logic [5:0] exp_vec();
    return {3'(m_seg), m_swap, m_pending, m_stop};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {bus.SEGMENT, bus.SWAP, bus.PENDING, bus.STOP};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.UPDATE = 1'b0;
    bus.LOOP_END = 1'b0;
  endtask

  task automatic request(input int seg, input logic [7:0] mode, input logic [63:0] value);
    bus.UPDATE = 1'b1;
    bus.REQ_SEGMENT = SW'(seg);
    bus.REQ_MODE = mode;
    bus.TRANSITION_VALUE = value;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want %b", obs_vec(), 6'b0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sync_idx();
    request(2, 8'h00, 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.PENDING !== 1'b1 || bus.SEGMENT !== 3'd0 || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL sync_idx_waiting: got %b want %b", obs_vec(), exp_vec());
      end
      tick();
    end
    bus.LOOP_END = 1'b1;
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd2 || bus.SWAP !== 1'b1 || bus.PENDING !== 1'b0) begin
      failures++; $display("FAIL sync_idx_swap: got %b want seg=2 swap=1 pending=0", obs_vec());
    end
    tick();
    checks++;
    if (bus.SWAP !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL sync_idx_swap_width: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sys_time();
    bus.SYS_TIME = 64'd990;
    request(1, 8'h01, 64'd1000);
    tick();
    for (int t = 991; t <= 1000; t++) begin
      checks++;
      if (bus.SEGMENT !== 3'd2 || bus.PENDING !== 1'b1) begin
        failures++; $display("FAIL sys_time_early: got %b at time %0d want seg=2 pending=1", obs_vec(), t - 1);
      end
      bus.SYS_TIME = 64'(t);
      tick();
    end
    checks++;
    if (bus.SEGMENT !== 3'd1 || bus.SWAP !== 1'b1 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL sys_time_swap: got %b want seg=1 swap=1", obs_vec());
    end
    bus.SYS_TIME = 64'd900;
    request(3, 8'h01, 64'd5);
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd1 || bus.PENDING !== 1'b1) begin
      failures++; $display("FAIL sys_time_past_arm: got %b want seg=1 pending=1", obs_vec());
    end
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd3 || bus.SWAP !== 1'b1 || bus.PENDING !== 1'b0) begin
      failures++; $display("FAIL sys_time_past_swap: got %b want seg=3 swap=1 pending=0", obs_vec());
    end
  endtask

  task automatic test_gpio();
    bus.GPIO_IN = 4'b1000;
    tick();
    request(0, 8'h02, 64'd3);
    tick();
    repeat (5) begin
      checks++;
      if (bus.SEGMENT !== 3'd3 || bus.PENDING !== 1'b1 || bus.SWAP !== 1'b0) begin
        failures++; $display("FAIL gpio_high_at_arm: got %b want seg=3 pending=1 swap=0", obs_vec());
      end
      tick();
    end
    bus.GPIO_IN = 4'b0000;
    tick();
    checks++;
    if (bus.PENDING !== 1'b1 || bus.SEGMENT !== 3'd3) begin
      failures++; $display("FAIL gpio_falling: got %b want seg=3 pending=1", obs_vec());
    end
    bus.GPIO_IN = 4'b1000;
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd0 || bus.SWAP !== 1'b1 || bus.PENDING !== 1'b0) begin
      failures++; $display("FAIL gpio_rising_swap: got %b want seg=0 swap=1 pending=0", obs_vec());
    end
  endtask

  task automatic test_finite_rep();
    bus.REP[1] = 16'd2;
    request(1, 8'h01, 64'd0);
    tick();
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd1 || bus.SWAP !== 1'b1) begin
      failures++; $display("FAIL rep_enter: got %b want seg=1 swap=1", obs_vec());
    end
    for (int k = 1; k <= 4; k++) begin
      bus.LOOP_END = 1'b1;
      tick();
      checks++;
      if (bus.STOP !== (k >= 3) || bus.SEGMENT !== 3'd1 || bus.SWAP !== 1'b0) begin
        failures++; $display("FAIL rep_loop%0d: got stop=%b seg=%0d want stop=%b seg=1", k, bus.STOP, bus.SEGMENT, k >= 3);
      end
      tick();
    end
    request(1, 8'h01, 64'd0);
    tick();
    checks++;
    if (bus.STOP !== 1'b1 || bus.PENDING !== 1'b1) begin
      failures++; $display("FAIL rep_stop_held_pending: got %b want stop=1 pending=1", obs_vec());
    end
    tick();
    checks++;
    if (bus.STOP !== 1'b0 || bus.SWAP !== 1'b1 || bus.SEGMENT !== 3'd1 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL rep_restart: got %b want seg=1 swap=1 stop=0", obs_vec());
    end
  endtask

  task automatic test_ext();
    int exp_seg [8] = '{0, 1, 2, 2, 2, 2, 2, 2};
    int swaps;
    bus.REP[0] = 16'd1; bus.REP[1] = 16'd0; bus.REP[2] = 16'hFFFF; bus.REP[3] = 16'd0;
    request(0, 8'hF0, 64'd0);
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd0 || bus.SWAP !== 1'b1 || bus.PENDING !== 1'b0) begin
      failures++; $display("FAIL ext_entry: got %b want seg=0 swap=1 pending=0", obs_vec());
    end
    swaps = 1;
    for (int i = 0; i < 8; i++) begin
      bus.LOOP_END = 1'b1;
      tick();
      swaps += int'(bus.SWAP);
      checks++;
      if (bus.SEGMENT !== 3'(exp_seg[i]) || bus.STOP !== 1'b0 || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL ext_step%0d: got seg=%0d stop=%b want seg=%0d stop=0", i, bus.SEGMENT, bus.STOP, exp_seg[i]);
      end
    end
    checks++;
    if (swaps !== 3) begin
      failures++; $display("FAIL ext_swap_count: got %0d want 3", swaps);
    end
  endtask

  task automatic test_edge_cases();
    request(5, 8'h00, 64'd0);
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd2 || bus.PENDING !== 1'b0 || bus.SWAP !== 1'b0) begin
      failures++; $display("FAIL invalid_segment: got %b want seg=2 pending=0 swap=0", obs_vec());
    end
    request(1, 8'h07, 64'd0);
    tick();
    checks++;
    if (bus.PENDING !== 1'b0 || bus.SEGMENT !== 3'd2) begin
      failures++; $display("FAIL unknown_mode: got %b want seg=2 pending=0", obs_vec());
    end
    request(1, 8'h00, 64'd0);
    tick();
    request(3, 8'h00, 64'd0);
    bus.LOOP_END = 1'b1;
    tick();
    checks++;
    if (bus.PENDING !== 1'b1 || bus.SEGMENT !== 3'd2 || bus.SWAP !== 1'b0) begin
      failures++; $display("FAIL update_wins: got %b want seg=2 pending=1 swap=0", obs_vec());
    end
    bus.LOOP_END = 1'b1;
    tick();
    checks++;
    if (bus.SEGMENT !== 3'd3 || bus.SWAP !== 1'b1) begin
      failures++; $display("FAIL latest_request: got %b want seg=3 swap=1", obs_vec());
    end
    request(1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.SEGMENT !== 3'd0 || bus.PENDING !== 1'b0 || bus.SWAP !== 1'b0) begin
      failures++; $display("FAIL reset_in_wait: got %b want all zero", obs_vec());
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== 6'b0 || obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_in_wait_after: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] modes [5] = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'h07};
    int reps [5] = '{0, 1, 2, 3, 16'hFFFF};
    int bad;
    logic [7:0] md;
    bad = 0;
    for (int s = 0; s < NSEG; s++) bus.REP[s] = 16'(reps[$urandom_range(0, 4)]);
    bus.SYS_TIME = 64'd2000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        md = modes[$urandom_range(0, 4)];
        if (md == 8'h01) request($urandom_range(0, 5), md, bus.SYS_TIME + 64'($urandom_range(0, 25)) - 64'd4);
        else request($urandom_range(0, 5), md, 64'($urandom_range(0, 3)));
      end
      bus.LOOP_END = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) bus.GPIO_IN = 4'($urandom_range(0, 15));
      if (c % 150 == 149) bus.REP[$urandom_range(0, NSEG - 1)] = 16'(reps[$urandom_range(0, 4)]);
      tick();
      bus.SYS_TIME = bus.SYS_TIME + 64'd1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; bad++;
        if (bad <= 10) $display("FAIL random_cycle%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.UPDATE = 1'b0;
    bus.REQ_SEGMENT = '0;
    bus.REQ_MODE = 8'h00;
    bus.TRANSITION_VALUE = '0;
    for (int s = 0; s < NSEG; s++) bus.REP[s] = 16'hFFFF;
    bus.SYS_TIME = '0;
    bus.GPIO_IN = '0;
    bus.LOOP_END = 1'b0;
    model_reset();

    test_reset();
    test_sync_idx();
    test_sys_time();
    test_gpio();
    test_finite_rep();
    test_ext();
    test_edge_cases();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
